// File: rtl/ram_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : ram_block_mover
// Desc     : COPY / FILL / CHECK block engine for a dual-port RAM.
//            Port 1 only reads, port 2 only writes.
// Revision : 1.0 - initial release
// ============================================================================
module ram_block_mover #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_data,
  output logic          busy,
  output logic          done,
  output logic          bad_mode,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [AW-1:0] ram_addr1,
  output logic          ram_wen1,
  output logic [DW-1:0] ram_data1,
  input  logic [DW-1:0] ram_q1,
  output logic [AW-1:0] ram_addr2,
  output logic          ram_wen2,
  output logic [DW-1:0] ram_data2
);

  localparam logic [1:0]  c_mode_copy  = 2'b00;
  localparam logic [1:0]  c_mode_fill  = 2'b01;
  localparam logic [1:0]  c_mode_bad   = 2'b11;
  localparam logic [AW:0] c_depth      = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] c_one        = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW:0]   r_len;
  logic [DW-1:0] r_fill;
  logic [AW:0]   r_idx;
  logic          r_s1_vld;
  logic [AW-1:0] r_s1_idx;
  logic          r_s2_vld;
  logic [AW-1:0] r_s2_idx;
  logic          r_busy;
  logic          r_done;
  logic          r_bad_mode;
  logic [AW:0]   r_err_count;
  logic [AW-1:0] r_first_err;
  logic [AW-1:0] r_addr1;
  logic [AW-1:0] r_addr2;
  logic          r_wen2;
  logic [DW-1:0] r_data2;
  logic          r_copy_wr;

  logic [AW:0]   w_len_clamped;
  logic [AW-1:0] w_idx_lo;

  assign w_len_clamped = (len > c_depth) ? c_depth : len;
  assign w_idx_lo      = r_idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_fill      <= '0;
      r_idx       <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_idx    <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_idx    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bad_mode  <= 1'b0;
      r_err_count <= '0;
      r_first_err <= '0;
      r_addr1     <= '0;
      r_addr2     <= '0;
      r_wen2      <= 1'b0;
      r_data2     <= '0;
      r_copy_wr   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_wen2    <= 1'b0;
      r_copy_wr <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;

      // Second pipeline stage: the read presented this cycle returns next cycle
      if (r_s1_vld) begin
        if (r_mode == c_mode_copy) begin
          r_wen2    <= 1'b1;
          r_addr2   <= r_dst + r_s1_idx;
          r_copy_wr <= 1'b1;
        end else begin
          r_s2_vld <= 1'b1;
          r_s2_idx <= r_s1_idx;
        end
      end

      if (r_s2_vld && (ram_q1 != r_fill)) begin
        r_err_count <= r_err_count + c_one;
        if (r_err_count == '0) begin
          r_first_err <= r_src + r_s2_idx;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode      <= mode;
            r_src       <= src_addr;
            r_dst       <= dst_addr;
            r_len       <= w_len_clamped;
            r_fill      <= fill_data;
            r_err_count <= '0;
            r_first_err <= '0;
            r_bad_mode  <= (mode == c_mode_bad);
            r_idx       <= c_one;
            if ((mode == c_mode_bad) || (w_len_clamped == '0)) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_RUN;
              if (mode == c_mode_fill) begin
                r_wen2  <= 1'b1;
                r_addr2 <= dst_addr;
                r_data2 <= fill_data;
              end else begin
                r_addr1  <= src_addr;
                r_s1_vld <= 1'b1;
                r_s1_idx <= '0;
              end
            end
          end
        end

        S_RUN: begin
          if (r_idx < r_len) begin
            r_idx <= r_idx + c_one;
            if (r_mode == c_mode_fill) begin
              r_wen2  <= 1'b1;
              r_addr2 <= r_dst + w_idx_lo;
              r_data2 <= r_fill;
            end else begin
              r_addr1  <= r_src + w_idx_lo;
              r_s1_vld <= 1'b1;
              r_s1_idx <= w_idx_lo;
            end
          end else if (r_mode == c_mode_fill) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign bad_mode       = r_bad_mode;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err;
  assign ram_addr1      = r_addr1;
  assign ram_wen1       = 1'b0;
  assign ram_data1      = '0;
  assign ram_addr2      = r_addr2;
  assign ram_wen2       = r_wen2;
  // Copy data arrives on ram_q1 in the very cycle it is written, so it bypasses r_data2
  assign ram_data2      = r_copy_wr ? ram_q1 : r_data2;

endmodule
`default_nettype wire

// File: tb/tb_ram_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_block_mover
// Desc     : Bench for ram_block_mover with a read-first RAM model and an
//            array-level reference of the memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_block_mover;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   len;
  logic [DW-1:0] fill_data;
  logic          busy;
  logic          done;
  logic          bad_mode;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] ram_addr1;
  logic          ram_wen1;
  logic [DW-1:0] ram_data1;
  logic [DW-1:0] ram_q1;
  logic [AW-1:0] ram_addr2;
  logic          ram_wen2;
  logic [DW-1:0] ram_data2;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] bd_img  [DEPTH];
  logic          bd_load = 1'b0;
  logic [DW-1:0] ref_mem [DEPTH];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ram_block_mover #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
    .fill_data      (fill_data),
    .busy           (busy),
    .done           (done),
    .bad_mode       (bad_mode),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .ram_addr1      (ram_addr1),
    .ram_wen1       (ram_wen1),
    .ram_data1      (ram_data1),
    .ram_q1         (ram_q1),
    .ram_addr2      (ram_addr2),
    .ram_wen2       (ram_wen2),
    .ram_data2      (ram_data2)
  );

  // Read-first dual-port RAM with a whole-image backdoor load
  always @(posedge clk) begin
    ram_q1 <= mem[ram_addr1];
    if (bd_load) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= bd_img[k];
    end else if (ram_wen2) begin
      mem[ram_addr2] <= ram_data2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    bd_img  = ref_mem;
    bd_load = 1'b1;
    step();
    bd_load = 1'b0;
  endtask

  // Mismatches between RAM and reference, ignoring n words starting at lo (wrapping)
  function automatic int mem_diff(input int lo, input int n);
    int cnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((((k - lo) & (DEPTH - 1)) >= n) && (mem[k] !== ref_mem[k])) cnt++;
    end
    return cnt;
  endfunction

  // Issues one command with cycle 0 = now and follows it to its done cycle
  task automatic run_cmd(input int m, input int s, input int d, input int ln,
                         input int f, input bit keep_start, input int pulse_cyc);
    int            L, exp_done, done_at, off, exp_err, exp_first;
    int            wr_bad, rd_bad, p1_bad, hs_bad;
    bit            bad, undef, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [DW-1:0] orig [DEPTH];
    orig      = ref_mem;
    L         = (ln > DEPTH) ? DEPTH : ln;
    bad       = (m == 3);
    off       = (d - s) & (DEPTH - 1);
    undef     = (m == 0) && (off >= 2) && (off < L);
    exp_done  = (bad || L == 0) ? 1 : ((m == 1) ? L + 1 : L + 2);
    done_at   = -1;
    wr_bad    = 0;
    rd_bad    = 0;
    p1_bad    = 0;
    hs_bad    = 0;
    check("idle_before_start", {busy, done}, 2'b00);
    start     = 1'b1;
    mode      = 2'(m);
    src_addr  = AW'(s);
    dst_addr  = AW'(d);
    len       = 7'(ln);
    fill_data = DW'(f);
    for (int c = 1; c <= exp_done; c++) begin
      step();
      if (!keep_start) start = (c == pulse_cyc);
      ew = 1'b0;
      ea = '0;
      ed = '0;
      if (!bad && L > 0) begin
        if (m == 1 && c <= L) begin
          ew = 1'b1; ea = AW'((d + c - 1) % DEPTH); ed = DW'(f);
        end
        if (m == 0 && c >= 2 && c <= L + 1) begin
          ew = 1'b1; ea = AW'((d + c - 2) % DEPTH); ed = orig[(s + c - 2) % DEPTH];
        end
        if ((m == 0 || m == 2) && c <= L && ram_addr1 !== AW'((s + c - 1) % DEPTH)) rd_bad++;
      end
      if (ram_wen2 !== ew || (ew && (ram_addr2 !== ea || (!undef && ram_data2 !== ed)))) wr_bad++;
      if (ram_wen1 !== 1'b0 || ram_data1 !== '0) p1_bad++;
      if (done !== (c == exp_done) || busy !== (c < exp_done)) hs_bad++;
      if (done === 1'b1 && done_at < 0) done_at = c;
    end

    exp_err   = 0;
    exp_first = 0;
    if (!bad) begin
      for (int i = 0; i < L; i++) begin
        case (m)
          0: ref_mem[(d + i) % DEPTH] = orig[(s + i) % DEPTH];
          1: ref_mem[(d + i) % DEPTH] = DW'(f);
          default: begin
            if (orig[(s + i) % DEPTH] != DW'(f)) begin
              if (exp_err == 0) exp_first = (s + i) % DEPTH;
              exp_err++;
            end
          end
        endcase
      end
    end

    check("done_cycle", done_at, exp_done);
    check("port2_writes", wr_bad, 0);
    check("port1_read_addr", rd_bad, 0);
    check("port1_tied_low", p1_bad, 0);
    check("busy_done_timing", hs_bad, 0);
    check("err_count", err_count, exp_err);
    check("first_err_addr", first_err_addr, exp_first);
    check("bad_mode", bad_mode, bad);
    check("mem_image", mem_diff(undef ? d : 0, undef ? L : 0), 0);
  endtask

  initial begin
    int hs;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = '0;
    src_addr  = '0;
    dst_addr  = '0;
    len       = '0;
    fill_data = '0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    step();
    preload();
    step();
    check("rst_ctrl", {busy, done, bad_mode}, 0);
    check("rst_err", {err_count, first_err_addr}, 0);
    check("rst_ram_ports", {ram_addr1, ram_wen1, ram_data1, ram_addr2, ram_wen2, ram_data2}, 0);
    rst = 1'b0;
    step();

    // FILL into the middle of random contents
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = DW'($urandom);
    preload();
    run_cmd(1, 0, 10, 5, 'hA5, 1'b0, 0);
    step();

    // COPY over the full region with an overlapping destination: timing only for data
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = DW'(k);
    preload();
    run_cmd(0, 0, 32, 64, 0, 1'b0, 0);
    step();
    preload();
    run_cmd(0, 40, 8, 30, 0, 1'b0, 0);
    step();
    run_cmd(0, 5, 6, 64, 0, 1'b0, 0);
    step();
    run_cmd(0, 7, 7, 20, 0, 1'b0, 0);
    step();

    // CHECK across the address wrap
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    ref_mem[62] = 8'h11;
    ref_mem[1]  = 8'h22;
    preload();
    run_cmd(2, 60, 0, 8, 0, 1'b0, 0);
    step();

    // Zero length, reserved mode, clamped length
    run_cmd(1, 0, 5, 0, 'h77, 1'b0, 0);
    step();
    run_cmd(3, 3, 4, 5, 'h77, 1'b0, 0);
    step();
    run_cmd(1, 0, 20, 100, 'h3C, 1'b0, 0);
    step();

    // start pulsed mid-command, then start held through FIN
    run_cmd(0, 0, 16, 8, 0, 1'b0, 3);
    hs = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) hs++;
    end
    check("single_done_after_pulse", hs, 0);
    run_cmd(1, 30, 30, 4, 'h99, 1'b1, 0);
    step();
    run_cmd(2, 30, 0, 4, 'h99, 1'b0, 0);
    step();

    // Reset in cycle 3 of a FILL
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = DW'($urandom);
    preload();
    start     = 1'b1;
    mode      = 2'd1;
    src_addr  = '0;
    dst_addr  = '0;
    len       = 7'd8;
    fill_data = 8'h5A;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_ram_ports", {ram_addr1, ram_wen1, ram_data1, ram_addr2, ram_wen2, ram_data2}, 0);
    check("rst_mid_ctrl", {busy, done, bad_mode, err_count, first_err_addr}, 0);
    hs = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || ram_wen2 !== 1'b0) hs++;
    end
    check("rst_mid_quiet", hs, 0);
    for (int i = 0; i < 3; i++) ref_mem[i] = 8'h5A;
    check("rst_mid_mem", mem_diff(0, 0), 0);
    run_cmd(1, 0, 0, 8, 'hC3, 1'b0, 0);
    step();

    // Random commands over a small data alphabet so CHECK sees both outcomes
    for (int it = 0; it < 24; it++) begin
      int m, s, d, ln, f, lc, o;
      if (it % 3 == 0) begin
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = DW'($urandom_range(0, 3));
        preload();
      end
      m  = int'($urandom_range(0, 3));
      s  = int'($urandom_range(0, DEPTH - 1));
      d  = int'($urandom_range(0, DEPTH - 1));
      ln = int'($urandom_range(0, 70));
      f  = int'($urandom_range(0, 3));
      lc = (ln > DEPTH) ? DEPTH : ln;
      o  = (d - s) & (DEPTH - 1);
      if (m == 0 && o >= 2 && o < lc) d = (lc < DEPTH) ? (s + lc) % DEPTH : s;
      run_cmd(m, s, d, ln, f, 1'b0, 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
